// File: rtl/trans_dispatch_arb_if.sv
// Ingress request bus and validator handshake for trans_dispatch_arb.
// slave = dispatcher side, master = ingress/validator side.
interface trans_dispatch_arb_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]     req_valid_i;
  logic [NUM_PORTS*128-1:0] req_data_i;
  logic [NUM_PORTS-1:0]     req_ready_o;
  logic [127:0]             val_data_o;
  logic                     val_valid_o;
  logic                     val_ack_i;

  modport slave (
    input  req_valid_i, req_data_i, val_ack_i,
    output req_ready_o, val_data_o, val_valid_o
  );

  modport master (
    output req_valid_i, req_data_i, val_ack_i,
    input  req_ready_o, val_data_o, val_valid_o
  );
endinterface

// File: rtl/trans_dispatch_arb.sv
// Round-robin ingress arbiter + FIFO + valid/ack dispatcher to the validator.
// Define TRANS_ARB_STATS_EN to add val_res_i and saturating stat counters.
module trans_dispatch_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 8
`ifdef TRANS_ARB_STATS_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  trans_dispatch_arb_if.slave  bus,
  input  logic                 blk_start_i
`ifdef TRANS_ARB_STATS_EN
  ,
  input  logic                 val_res_i,
  output logic [CNT_W-1:0]     stat_disp_o,
  output logic [CNT_W-1:0]     stat_ok_o
`endif
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] GAP     = 2'd2;

  logic [1:0]           state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        idx;
  logic                 hit;
  logic [NUM_PORTS-1:0] grant;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 blk_pend;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [127:0]         head;
  logic [127:0]         val_data_q;
  logic                 val_valid_q;
  logic [127:0]         mem [FIFO_DEPTH];
  logic [127:0]         port_data [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_data[p] = bus.req_data_i[p*128 +: 128];
    end
  end

  assign full = (count == (AW+1)'(FIFO_DEPTH));

  always_comb begin
    hit     = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    grant   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PW'((32'(rr_ptr) + 32'(i)) % NUM_PORTS);
      if (!hit && bus.req_valid_i[idx]) begin
        hit     = 1'b1;
        gnt_idx = idx;
      end
    end
    if (hit && !full) grant[gnt_idx] = 1'b1;
  end

  assign push            = |grant;
  assign pop             = (state == PRESENT) && bus.val_ack_i;
  assign head            = mem[rd_ptr];
  assign bus.req_ready_o = grant;
  assign bus.val_data_o  = val_data_q;
  assign bus.val_valid_o = val_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gnt_idx == PW'(NUM_PORTS-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Storage is not reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= port_data[gnt_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_pend <= 1'b0;
    end else if (blk_start_i) begin
      blk_pend <= 1'b1;
    end else if (pop) begin
      blk_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      val_valid_q <= 1'b0;
      val_data_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            val_data_q  <= {head[127:10], head[9] | blk_pend, head[8:0]};
            val_valid_q <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.val_ack_i) begin
            val_valid_q <= 1'b0;
            state       <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          val_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef TRANS_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_disp_o <= '0;
      stat_ok_o   <= '0;
    end else begin
      if (pop && (stat_disp_o != '1)) stat_disp_o <= stat_disp_o + 1'b1;
      if (val_res_i && (stat_ok_o != '1)) stat_ok_o <= stat_ok_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_trans_dispatch_arb.sv
// Randomized + directed bench for trans_dispatch_arb against a queue model.
// Builds with or without TRANS_ARB_STATS_EN.
module tb_trans_dispatch_arb;

  localparam int NP    = 4;
  localparam int DEPTH = 8;
`ifdef TRANS_ARB_STATS_EN
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  logic          val_res;
  logic [CW-1:0] stat_disp;
  logic [CW-1:0] stat_ok;
  int            m_disp;
  int            m_ok;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic blk_start;

  always #5 clk = ~clk;

  trans_dispatch_arb_if #(.NUM_PORTS(NP)) bus ();

  trans_dispatch_arb #(
    .NUM_PORTS  (NP),
    .FIFO_DEPTH (DEPTH)
`ifdef TRANS_ARB_STATS_EN
    ,
    .CNT_W      (CW)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .blk_start_i (blk_start)
`ifdef TRANS_ARB_STATS_EN
    ,
    .val_res_i   (val_res),
    .stat_disp_o (stat_disp),
    .stat_ok_o   (stat_ok)
`endif
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] q [$];
  int           rr;
  int           cool;
  int           age;
  bit           m_valid;
  bit           m_blk;
  logic [127:0] m_data;
  logic [127:0] pdata [NP];
  bit           clr9 = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] newd();
    logic [127:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (clr9) d[9] = 1'b0;
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    rr      = 0;
    cool    = 0;
    age     = 0;
    m_valid = 1'b0;
    m_blk   = 1'b0;
    m_data  = '0;
`ifdef TRANS_ARB_STATS_EN
    m_disp  = 0;
    m_ok    = 0;
`endif
  endtask

  task automatic drive_idle();
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.val_ack_i   = 1'b0;
    blk_start       = 1'b0;
`ifdef TRANS_ARB_STATS_EN
    val_res         = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    chk("rst_valid", bus.val_valid_o, 0);
    chk("rst_data", bus.val_data_o, 0);
    chk("rst_ready", bus.req_ready_o, 0);
`ifdef TRANS_ARB_STATS_EN
    chk("rst_disp", stat_disp, 0);
    chk("rst_ok", stat_ok, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, check, then advance the model over the edge.
  task automatic step(input logic [NP-1:0] v, input logic ack,
                      input logic blk, input logic res);
    int           g;
    int           pre;
    bit           pop;
    logic [NP-1:0] er;
    logic [127:0] head;
    logic [NP*128-1:0] dv;
    @(negedge clk);
    dv = '0;
    for (int p = 0; p < NP; p++) dv[p*128 +: 128] = pdata[p];
    bus.req_valid_i = v;
    bus.req_data_i  = dv;
    bus.val_ack_i   = ack;
    blk_start       = blk;
`ifdef TRANS_ARB_STATS_EN
    val_res         = res;
`endif
    #1;
    g  = -1;
    er = '0;
    if (q.size() < DEPTH) begin
      for (int k = 0; k < NP; k++) begin
        if (g < 0 && v[(rr + k) % NP]) g = (rr + k) % NP;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("ready", bus.req_ready_o, er);
    chk("valid", bus.val_valid_o, m_valid);
    chk("data", bus.val_data_o, m_data);
`ifdef TRANS_ARB_STATS_EN
    chk("disp", stat_disp, m_disp);
    chk("ok", stat_ok, m_ok);
`endif
    pre  = q.size();
    head = (pre > 0) ? q[0] : '0;
    pop  = m_valid && ack;
    if (pop) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back(pdata[g]);
      rr       = (g + 1) % NP;
      pdata[g] = newd();
    end
    if (m_valid) begin
      if (ack) begin
        m_valid = 1'b0;
        cool    = 1;
      end
    end else if (cool > 0) begin
      cool--;
    end else if (pre > 0) begin
      m_valid = 1'b1;
      m_data  = head;
      if (m_blk) m_data[9] = 1'b1;
    end
    if (blk) m_blk = 1'b1;
    else if (pop) m_blk = 1'b0;
`ifdef TRANS_ARB_STATS_EN
    if (pop && m_disp < CMAX) m_disp++;
    if (res && m_ok < CMAX) m_ok++;
`else
    if (res) n_tests = n_tests + 0;
`endif
    age = m_valid ? age + 1 : 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) step('0, age >= 1, 1'b0, 1'b0);
    chk("drained", q.size(), 0);
  endtask

  initial begin
    int ackp;
    logic [NP-1:0] v;
    drive_idle();
    for (int p = 0; p < NP; p++) pdata[p] = newd();
    model_reset();
    do_reset();

    // single push held 20+ cycles, then ack and the 2-cycle gap
    pdata[0] = {16{8'hA5}};
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step('0, 1'b0, 1'b0, 1'b0);

    // all ports busy, ack on the third valid cycle
    for (int i = 0; i < 60; i++) step(4'b1111, age >= 3, 1'b0, 1'b1);
    drain();

    // fill FIFO from port1 with no acks, then release one slot
    for (int i = 0; i < 12; i++) step(4'b0010, 1'b0, 1'b0, 1'b0);
    chk("full", q.size(), DEPTH);
    step(4'b0010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, 1'b0, 1'b0);
    drain();

    // block-start flag, including a pulse coincident with the ack
    clr9 = 1'b1;
    for (int p = 0; p < NP; p++) pdata[p] = newd();
    step('0, 1'b0, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6 && age < 2; i++) step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step('0, age >= 2, 1'b0, 1'b0);
    drain();
    clr9 = 1'b0;

    // reset while presenting with a queued backlog
    for (int i = 0; i < 6; i++) step(4'b1000, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0, 1'b0);

    // random traffic with shifting ack pressure
    ackp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ackp = $urandom_range(5, 95);
      if (c == 1500) do_reset();
      v = NP'($urandom());
      if ($urandom_range(0, 3) == 0) v = '0;
      step(v, $urandom_range(0, 99) < ackp, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
